ed25519_sign_loader: RTL and testbench

Bus-side front end for the Ed25519 signing S-core in the Keystone accelerator. Collects the three 512-bit SHA-512 digests (hashed secret key, hashed nonce/RAM, hashed R‖A‖M) as 64-bit words and hands them to `ed25519_sign_S_core_TOP` over its ready/enable handshake. It byte-reverses and strips the key digest, captures the 253-bit result, re-inserts the three zero bits, and exposes S as four readable 64-bit words.

---
 rtl/ed25519_sign_pkg.sv | 36 +++
 rtl/ed25519_sign_wbuf.sv | 34 +++
 rtl/ed25519_sign_loader.sv | 136 +++++++++++++
 tb/tb_ed25519_sign_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_sign_pkg.sv
// Shared types, constants and data-shaping helpers for the Ed25519 sign loader.
package ed25519_sign_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_RAM = 2'd1;
  localparam logic [1:0] SEL_SM  = 2'd2;

  localparam int WORDS  = 8;
  localparam int WORD_W = 64;
  localparam int BUF_W  = WORDS * WORD_W;
  localparam int KEY_W  = 251;
  localparam int SIGN_W = 253;
  localparam int S_W    = 256;

  function automatic logic [BUF_W-1:0] byte_rev512(input logic [BUF_W-1:0] v);
    logic [BUF_W-1:0] r;
    r = {BUF_W{1'b0}};
    for (int i = 0; i < 64; i++) begin
      r[8*i +: 8] = v[8*(63-i) +: 8];
    end
    return r;
  endfunction

  // Drops the clamped bits 506:504 and 263:262 and the low half of the reversed key.
  function automatic logic [KEY_W-1:0] key_strip(input logic [BUF_W-1:0] k);
    return {k[511:507], k[503:264], k[261:256]};
  endfunction

endpackage

// File: rtl/ed25519_sign_wbuf.sv
// One 512-bit digest buffer filled as eight 64-bit words, with a per-word valid mask.
module ed25519_sign_wbuf
  import ed25519_sign_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_idx,
  input  logic [63:0]      wr_data,
  input  logic             clr,
  output logic [BUF_W-1:0] data,
  output logic             full
);

  logic [BUF_W-1:0] data_r;
  logic [WORDS-1:0] mask_r;

  // Word storage and valid mask; clear only drops the mask, data is overwritten later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {BUF_W{1'b0}};
      mask_r <= {WORDS{1'b0}};
    end else if (clr) begin
      mask_r <= {WORDS{1'b0}};
    end else if (wr_en) begin
      data_r[{wr_idx, 6'b000000} +: WORD_W] <= wr_data;
      mask_r[wr_idx]                        <= 1'b1;
    end
  end

  assign data = data_r;
  assign full = &mask_r;

endmodule

// File: rtl/ed25519_sign_loader.sv
// Bus front end for the Ed25519 S core: gathers three digests, runs the core handshake,
// and exposes the 256-bit S result as four readable words.
module ed25519_sign_loader
  import ed25519_sign_pkg::*;
(
  input  logic              ICLK,
  input  logic              IRST_N,
  input  logic              IWR_EN,
  input  logic [1:0]        IWR_SEL,
  input  logic [2:0]        IWR_IDX,
  input  logic [63:0]       IWR_DATA,
  input  logic              ISTART,
  input  logic [1:0]        IRD_IDX,
  output logic [63:0]       ORD_DATA,
  output logic              OBUSY,
  output logic              ODONE,
  output logic              OERR,
  output logic              OCORE_EN,
  input  logic              ICORE_READY,
  input  logic              ICORE_DONE,
  output logic [KEY_W-1:0]  OCORE_KEY,
  output logic [BUF_W-1:0]  OCORE_RAM,
  output logic [BUF_W-1:0]  OCORE_SM,
  input  logic [SIGN_W-1:0] ICORE_SIGN
);

  state_t           state_r, state_s;
  logic             core_en_r, busy_r, done_r, err_r;
  logic [S_W-1:0]   s_r;
  logic [63:0]      rd_r;
  logic             wr_legal_s, wr_bad_sel_s, wr_ok_s, err_s, clr_s, s_load_s;
  logic             key_full_s, ram_full_s, sm_full_s;
  logic [BUF_W-1:0] key_buf_s;

  assign wr_legal_s   = IWR_EN && (IWR_SEL != 2'd3);
  assign wr_bad_sel_s = IWR_EN && (IWR_SEL == 2'd3);

  ed25519_sign_wbuf u_key (
    .clk(ICLK), .rst_n(IRST_N), .wr_en(wr_ok_s && (IWR_SEL == SEL_KEY)),
    .wr_idx(IWR_IDX), .wr_data(IWR_DATA), .clr(clr_s), .data(key_buf_s), .full(key_full_s)
  );
  ed25519_sign_wbuf u_ram (
    .clk(ICLK), .rst_n(IRST_N), .wr_en(wr_ok_s && (IWR_SEL == SEL_RAM)),
    .wr_idx(IWR_IDX), .wr_data(IWR_DATA), .clr(clr_s), .data(OCORE_RAM), .full(ram_full_s)
  );
  ed25519_sign_wbuf u_sm (
    .clk(ICLK), .rst_n(IRST_N), .wr_en(wr_ok_s && (IWR_SEL == SEL_SM)),
    .wr_idx(IWR_IDX), .wr_data(IWR_DATA), .clr(clr_s), .data(OCORE_SM), .full(sm_full_s)
  );

  assign OCORE_KEY = key_strip(byte_rev512(key_buf_s));

  // Next-state and command acceptance; buffers are write-locked while the core owns them.
  always_comb begin
    state_s  = state_r;
    wr_ok_s  = 1'b0;
    err_s    = 1'b0;
    clr_s    = 1'b0;
    s_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        wr_ok_s = wr_legal_s;
        err_s   = wr_bad_sel_s;
        if (ISTART) begin
          if (key_full_s && ram_full_s && sm_full_s) begin
            state_s = ST_WAIT_RDY;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        err_s = IWR_EN;
        if (core_en_r && ICORE_READY) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_WAIT_RDY;
        end
      end
      ST_RUN: begin
        err_s = IWR_EN;
        if (ICORE_DONE) begin
          state_s  = ST_DONE;
          clr_s    = 1'b1;
          s_load_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        wr_ok_s = wr_legal_s;
        err_s   = wr_bad_sel_s || ISTART;
        if (wr_legal_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, registered status/handshake outputs, S capture and read port.
  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) begin
      state_r   <= ST_IDLE;
      core_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      s_r       <= {S_W{1'b0}};
      rd_r      <= 64'd0;
    end else begin
      state_r   <= state_s;
      core_en_r <= (state_s == ST_WAIT_RDY);
      busy_r    <= (state_s == ST_WAIT_RDY) || (state_s == ST_RUN);
      done_r    <= (state_s == ST_DONE);
      err_r     <= err_s;
      if (s_load_s) begin
        s_r <= {ICORE_SIGN[252:5], 3'b000, ICORE_SIGN[4:0]};
      end
      rd_r <= s_r[{IRD_IDX, 6'b000000} +: 64];
    end
  end

  assign OCORE_EN = core_en_r;
  assign OBUSY    = busy_r;
  assign ODONE    = done_r;
  assign OERR     = err_r;
  assign ORD_DATA = rd_r;

endmodule

// File: tb/tb_ed25519_sign_loader.sv
// Self-checking bench: random digest words against a word-array model, a stand-in core
// driving known S values (RFC 8032 test 1, all ones), and the error/reset corner cases.
module tb_ed25519_sign_loader;

  logic         ICLK = 1'b0;
  logic         IRST_N, IWR_EN, ISTART, ICORE_READY, ICORE_DONE;
  logic [1:0]   IWR_SEL, IRD_IDX;
  logic [2:0]   IWR_IDX;
  logic [63:0]  IWR_DATA, ORD_DATA;
  logic         OBUSY, ODONE, OERR, OCORE_EN;
  logic [250:0] OCORE_KEY;
  logic [511:0] OCORE_RAM, OCORE_SM;
  logic [252:0] ICORE_SIGN;

  int checks = 0, errors = 0, en_cnt = 0;
  logic [63:0] key_m [8];
  logic [63:0] ram_m [8];
  logic [63:0] sm_m  [8];
  logic [63:0] rfc_w [4];
  logic [255:0] rfc_s;

  ed25519_sign_loader dut (
    .ICLK(ICLK), .IRST_N(IRST_N), .IWR_EN(IWR_EN), .IWR_SEL(IWR_SEL), .IWR_IDX(IWR_IDX),
    .IWR_DATA(IWR_DATA), .ISTART(ISTART), .IRD_IDX(IRD_IDX), .ORD_DATA(ORD_DATA),
    .OBUSY(OBUSY), .ODONE(ODONE), .OERR(OERR), .OCORE_EN(OCORE_EN),
    .ICORE_READY(ICORE_READY), .ICORE_DONE(ICORE_DONE), .OCORE_KEY(OCORE_KEY),
    .OCORE_RAM(OCORE_RAM), .OCORE_SM(OCORE_SM), .ICORE_SIGN(ICORE_SIGN)
  );

  always #5 ICLK = ~ICLK;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ICLK);
    #1;
    if (OCORE_EN) en_cnt++;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [2:0] idx, input logic [63:0] d);
    IWR_EN = 1'b1; IWR_SEL = sel; IWR_IDX = idx; IWR_DATA = d;
    tick();
    IWR_EN = 1'b0;
  endtask

  task automatic pulse_start();
    ISTART = 1'b1;
    tick();
    ISTART = 1'b0;
  endtask

  task automatic read_word(input logic [1:0] idx, input logic [63:0] exp, input string tag);
    IRD_IDX = idx;
    tick();
    check_eq(tag, ORD_DATA, exp);
  endtask

  // Fill all three buffers (optionally leaving sm word 7 out); key can be bytes 0x00..0x3F.
  task automatic load(input bit skip_last, input bit key_pattern);
    logic [63:0] d;
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 8; w++) begin
        d = {$urandom, $urandom};
        if (s == 0 && key_pattern) begin
          for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8*w + k);
        end
        if (!(skip_last && s == 2 && w == 7)) begin
          case (s)
            0:       key_m[w] = d;
            1:       ram_m[w] = d;
            default: sm_m[w]  = d;
          endcase
          wr(2'(s), 3'(w), d);
        end
      end
    end
  endtask

  function automatic logic [511:0] pack(input logic [63:0] m [8]);
    logic [511:0] v;
    v = '0;
    for (int w = 0; w < 8; w++) v = v | (512'(m[w]) << (64*w));
    return v;
  endfunction

  // Byte-reverse the key digest, then keep bits 256..511 except the five clamped ones.
  function automatic logic [250:0] exp_key();
    logic [511:0] k, r;
    logic [250:0] o;
    int n;
    k = pack(key_m);
    r = '0;
    for (int j = 0; j < 64; j++) r[8*j +: 8] = k[8*(63-j) +: 8];
    n = 0;
    o = '0;
    for (int p = 256; p < 512; p++) begin
      if (!(p >= 504 && p <= 506) && p != 262 && p != 263) begin
        o[n] = r[p];
        n++;
      end
    end
    return o;
  endfunction

  function automatic logic [255:0] exp_s(input logic [252:0] sg);
    logic [255:0] hi;
    hi = 256'(sg >> 5);
    return (hi << 8) | 256'(sg & 253'd31);
  endfunction

  task automatic check_bufs(input string tag);
    check_eq({tag, "_key"}, OCORE_KEY, exp_key());
    check_eq({tag, "_ram"}, OCORE_RAM, pack(ram_m));
    check_eq({tag, "_sm"},  OCORE_SM,  pack(sm_m));
  endtask

  initial begin
    logic [255:0] s_exp;
    logic [63:0]  d;
    bit           en_ok;
    IRST_N = 1'b0; IWR_EN = 1'b0; IWR_SEL = 2'd0; IWR_IDX = 3'd0; IWR_DATA = 64'd0;
    ISTART = 1'b0; IRD_IDX = 2'd0; ICORE_READY = 1'b0; ICORE_DONE = 1'b0; ICORE_SIGN = '0;
    for (int w = 0; w < 8; w++) begin key_m[w] = 64'd0; ram_m[w] = 64'd0; sm_m[w] = 64'd0; end
    rfc_w[3] = 64'h5fb8821590a33bac; rfc_w[2] = 64'hc61e39701cf9b46b;
    rfc_w[1] = 64'hd25bf5f0595bbe24; rfc_w[0] = 64'h655141438e7a100b;
    rfc_s = {rfc_w[3], rfc_w[2], rfc_w[1], rfc_w[0]};

    repeat (2) @(posedge ICLK);
    #1;
    check_eq("rst_busy", OBUSY, 1'b0);
    check_eq("rst_done", ODONE, 1'b0);
    check_eq("rst_err",  OERR, 1'b0);
    check_eq("rst_en",   OCORE_EN, 1'b0);
    check_eq("rst_rd",   ORD_DATA, 64'd0);
    check_bufs("rst");
    @(negedge ICLK);
    IRST_N = 1'b1;

    // Incomplete start: 23 words then ISTART
    load(1'b1, 1'b0);
    pulse_start();
    check_eq("inc_err",  OERR, 1'b1);
    check_eq("inc_busy", OBUSY, 1'b0);
    check_eq("inc_en",   OCORE_EN, 1'b0);
    tick();
    check_eq("inc_err_once", OERR, 1'b0);
    d = {$urandom, $urandom};
    sm_m[7] = d;
    wr(2'd2, 3'd7, d);

    // Delayed ready with a rejected write in the window
    en_cnt = 0;
    pulse_start();
    check_eq("start_busy", OBUSY, 1'b1);
    check_eq("start_en",   OCORE_EN, 1'b1);
    en_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        IWR_EN = 1'b1; IWR_SEL = 2'd0; IWR_IDX = 3'd0; IWR_DATA = ~key_m[0];
      end
      tick();
      IWR_EN = 1'b0;
      if (i == 3) check_eq("wait_wr_err", OERR, 1'b1);
      en_ok = en_ok && OCORE_EN;
    end
    check_eq("wait_en_hold", en_ok, 1'b1);
    check_bufs("wait_frozen");
    ICORE_READY = 1'b1;
    tick();
    ICORE_READY = 1'b0;
    check_eq("hs_en_low", OCORE_EN, 1'b0);
    check_eq("hs_busy",   OBUSY, 1'b1);
    check_eq("hs_en_cnt", en_cnt, 11);
    tick();
    ICORE_SIGN = {253{1'b1}};
    ICORE_DONE = 1'b1;
    tick();
    ICORE_DONE = 1'b0;
    check_eq("ones_done", ODONE, 1'b1);
    check_eq("ones_busy", OBUSY, 1'b0);
    ICORE_SIGN = '0;
    ICORE_DONE = 1'b1;
    tick();
    ICORE_DONE = 1'b0;
    s_exp = exp_s({253{1'b1}});
    for (int i = 0; i < 4; i++) read_word(2'(i), s_exp[64*i +: 64], "ones_word");
    read_word(2'd0, 64'hFFFF_FFFF_FFFF_FF1F, "ones_w0_const");
    pulse_start();
    check_eq("done_start_err", OERR, 1'b1);
    check_eq("done_hold",      ODONE, 1'b1);

    // DONE exit by a write; S stays readable; illegal select rejected
    d = {$urandom, $urandom};
    key_m[0] = d;
    wr(2'd0, 3'd0, d);
    check_eq("exit_done", ODONE, 1'b0);
    check_eq("exit_busy", OBUSY, 1'b0);
    read_word(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, "exit_s_kept");
    wr(2'd3, 3'd1, ~key_m[1]);
    check_eq("sel3_err", OERR, 1'b1);
    check_bufs("sel3");

    // Key strip plus RFC 8032 test 1 with ready already high
    load(1'b0, 1'b1);
    check_bufs("strip");
    ICORE_READY = 1'b1;
    en_cnt = 0;
    pulse_start();
    tick();
    tick();
    ICORE_SIGN = 253'(((rfc_s >> 8) << 5) | (rfc_s & 256'd31));
    ICORE_DONE = 1'b1;
    tick();
    ICORE_DONE = 1'b0;
    check_eq("rfc_en_cnt", en_cnt, 1);
    check_eq("rfc_done",   ODONE, 1'b1);
    for (int i = 0; i < 4; i++) read_word(2'(i), rfc_w[i], "rfc_word");

    // Reset in the middle of RUN
    d = {$urandom, $urandom};
    key_m[0] = d;
    wr(2'd0, 3'd0, d);
    load(1'b0, 1'b0);
    pulse_start();
    tick();
    check_eq("run_busy", OBUSY, 1'b1);
    #1;
    IRST_N = 1'b0;
    #1;
    for (int w = 0; w < 8; w++) begin key_m[w] = 64'd0; ram_m[w] = 64'd0; sm_m[w] = 64'd0; end
    check_eq("mid_rst_busy", OBUSY, 1'b0);
    check_eq("mid_rst_done", ODONE, 1'b0);
    check_eq("mid_rst_en",   OCORE_EN, 1'b0);
    check_eq("mid_rst_rd",   ORD_DATA, 64'd0);
    check_bufs("mid_rst");
    @(negedge ICLK);
    IRST_N = 1'b1;
    pulse_start();
    check_eq("post_rst_err",  OERR, 1'b1);
    check_eq("post_rst_busy", OBUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
